// File: rtl/piso_serializer_pkg.sv
`default_nettype none
// ============================================================================
// piso_serializer_pkg : state encoding and defaults shared with detector side
// Rev 1.0
// ============================================================================
package piso_serializer_pkg;

  localparam logic ST_IDLE          = 1'b0;
  localparam logic ST_SHIFT         = 1'b1;

  // Idle line level that keeps the downstream detector in its start state
  localparam logic DEFAULT_IDLE_BIT = 1'b1;

  typedef enum logic {
    S_IDLE  = ST_IDLE,
    S_SHIFT = ST_SHIFT
  } piso_state_e;

endpackage : piso_serializer_pkg
`default_nettype wire

// File: rtl/piso_serializer.sv
`default_nettype none
// ============================================================================
// piso_serializer : valid/ready parallel-in, one-bit-per-clock serial-out stage
// Rev 1.0
// ============================================================================
module piso_serializer
  import piso_serializer_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1,
  parameter bit IDLE_BIT  = DEFAULT_IDLE_BIT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             dout_bit,
  output logic             dout_valid,
  output logic             last_bit
);

  localparam int            CW       = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  piso_state_e      state_q, state_d;
  logic [WIDTH-1:0] sreg_q, sreg_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic [WIDTH-1:0] sreg_shifted;
  logic             head_bit;
  logic             busy;
  logic             accept;

  // The output end of the shift register depends on bit order
  generate
    if (MSB_FIRST) begin : g_msb_first
      assign head_bit     = sreg_q[WIDTH-1];
      assign sreg_shifted = {sreg_q[WIDTH-2:0], 1'b0};
    end else begin : g_lsb_first
      assign head_bit     = sreg_q[0];
      assign sreg_shifted = {1'b0, sreg_q[WIDTH-1:1]};
    end
  endgenerate

  assign busy       = (state_q == S_SHIFT);
  assign last_bit   = busy && (cnt_q == CNT_LAST);
  assign din_ready  = !busy || last_bit;
  assign dout_valid = busy;
  assign dout_bit   = busy ? head_bit : IDLE_BIT;
  assign accept     = din_valid && din_ready;

  always_comb begin
    state_d = state_q;
    sreg_d  = sreg_q;
    cnt_d   = cnt_q;
    if (accept) begin
      // Loading on the last_bit cycle gives gap-free back-to-back words
      state_d = S_SHIFT;
      sreg_d  = din;
      cnt_d   = '0;
    end else if (busy) begin
      if (cnt_q == CNT_LAST) begin
        state_d = S_IDLE;
      end else begin
        sreg_d = sreg_shifted;
        cnt_d  = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      sreg_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule : piso_serializer
`default_nettype wire

// File: tb/tb_piso_serializer.sv
`default_nettype none
// ============================================================================
// tb_piso_serializer : table-driven words with a bit-level scoreboard
// Rev 1.0
// ============================================================================
module tb_piso_serializer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] din = '0;
  logic       din_valid = 1'b0;
  logic       din_ready, dout_bit, dout_valid, last_bit;

  logic [3:0] din4 = '0;
  logic       din4_valid = 1'b0;
  logic       d4_ready, d4_bit, d4_valid, d4_last;

  always #5 clk = ~clk;

  piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_BIT(1'b1)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .din       (din),
    .din_valid (din_valid),
    .din_ready (din_ready),
    .dout_bit  (dout_bit),
    .dout_valid(dout_valid),
    .last_bit  (last_bit)
  );

  piso_serializer #(.WIDTH(4), .MSB_FIRST(1'b0), .IDLE_BIT(1'b1)) u_dut_lsb (
    .clk       (clk),
    .rst       (rst),
    .din       (din4),
    .din_valid (din4_valid),
    .din_ready (d4_ready),
    .dout_bit  (d4_bit),
    .dout_valid(d4_valid),
    .last_bit  (d4_last)
  );

  typedef struct packed {
    logic b;
    logic last;
  } exp_bit_t;

  // seq holds the required serial stream, seq[7] transmitted first
  typedef struct {
    logic [7:0] din;
    logic [7:0] seq;
    bit         chain;
  } vec_t;

  exp_bit_t   exp_q[$];
  vec_t       vt[6];
  logic [7:0] drv_seq = '0;
  bit         model_ready = 1'b1;
  int         n_cmp = 0;
  int         n_err = 0;

  task automatic chk(input string nm, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
    end
  endtask

  // Pushes the required bits on each accept edge, checks outputs on falling edges
  task automatic monitor();
    exp_bit_t e;
    forever begin
      @(posedge clk or negedge clk);
      if (clk) begin
        if (!rst && din_valid && model_ready) begin
          for (int j = 0; j < 8; j++) exp_q.push_back('{b: drv_seq[7-j], last: (j == 7)});
        end
      end else begin
        if (rst) exp_q.delete();
        model_ready = (exp_q.size() <= 1);
        chk("din_ready", din_ready, model_ready);
        if (exp_q.size() == 0) begin
          chk("idle_valid", dout_valid, 1'b0);
          chk("idle_bit", dout_bit, 1'b1);
          chk("idle_last", last_bit, 1'b0);
        end else begin
          e = exp_q.pop_front();
          chk("dout_valid", dout_valid, 1'b1);
          chk("dout_bit", dout_bit, e.b);
          chk("last_bit", last_bit, e.last);
        end
      end
    end
  endtask

  task automatic send(input logic [7:0] w, input logic [7:0] s);
    bit done;
    done      = 1'b0;
    din       = w;
    drv_seq   = s;
    din_valid = 1'b1;
    for (int i = 0; i < 40 && !done; i++) begin
      @(posedge clk);
      if (!rst && model_ready) done = 1'b1;
    end
    if (!done) begin
      n_cmp++;
      n_err++;
      $display("FAIL send_timeout: word %h not accepted within 40 cycles", w);
    end
    #1 din_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) @(negedge clk);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain_timeout: %0d bits left, expected 0", exp_q.size());
    end
  endtask

  logic [0:3] lsb_seq  = 4'b0110;
  logic [0:3] lsb_last = 4'b0001;

  initial begin
    vt[0] = '{din: 8'h36, seq: 8'b0011_0110, chain: 1'b0};
    vt[1] = '{din: 8'hA5, seq: 8'b1010_0101, chain: 1'b1};
    vt[2] = '{din: 8'h0F, seq: 8'b0000_1111, chain: 1'b0};
    vt[3] = '{din: 8'h00, seq: 8'b0000_0000, chain: 1'b1};
    vt[4] = '{din: 8'hFF, seq: 8'b1111_1111, chain: 1'b0};
    vt[5] = '{din: 8'h81, seq: 8'b1000_0001, chain: 1'b0};

    fork
      monitor();
    join_none

    // Reset for 3 cycles then 10 idle cycles
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (10) @(negedge clk);

    // Single words, back-to-back pairs and a stalled word
    for (int i = 0; i < 6; i++) begin
      send(vt[i].din, vt[i].seq);
      if (!vt[i].chain) begin
        drain();
        repeat (2) @(negedge clk);
      end
    end

    // Reset in the middle of a word, with a word offered while in reset
    send(8'h36, 8'b0011_0110);
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("rst_async_valid", dout_valid, 1'b0);
    chk("rst_async_bit", dout_bit, 1'b1);
    chk("rst_async_last", last_bit, 1'b0);
    din       = 8'h55;
    din_valid = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    din_valid = 1'b0;
    repeat (3) @(negedge clk);
    send(8'hC3, 8'b1100_0011);
    drain();
    repeat (2) @(negedge clk);

    // LSB-first, WIDTH = 4
    @(negedge clk);
    chk("lsb_idle_ready", d4_ready, 1'b1);
    din4       = 4'b0110;
    din4_valid = 1'b1;
    @(posedge clk);
    #1 din4_valid = 1'b0;
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      chk("lsb_valid", d4_valid, 1'b1);
      chk("lsb_bit", d4_bit, lsb_seq[j]);
      chk("lsb_last", d4_last, lsb_last[j]);
    end
    @(negedge clk);
    chk("lsb_idle_valid", d4_valid, 1'b0);
    chk("lsb_idle_bit", d4_bit, 1'b1);

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_piso_serializer
`default_nettype wire
